// File: rtl/mult_rr_scheduler_pkg.sv
// Shared constants and helpers for the round-robin multiplier scheduler.
// Operand/product widths, requester-tag width function, one-hot decode.
package mult_rr_scheduler_pkg;

    localparam int OPW    = 16;
    localparam int PW     = 32;
    localparam int MAXREQ = 16;

    function automatic int idw_f(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [MAXREQ-1:0] onehot16(input logic [3:0] idx);
        logic [MAXREQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/mult_rr_scheduler_boothwallace.sv
// Combinational signed 16x16 multiplier: radix-4 Booth partial products
// reduced by a carry-save tree. Ports: x, y (two's complement), p (x*y).
module boothwallace
    import mult_rr_scheduler_pkg::*;
(
    input  logic [OPW-1:0] x,
    input  logic [OPW-1:0] y,
    output logic [PW-1:0]  p
);

    function automatic logic [2*PW-1:0] csa(
        input logic [PW-1:0] a,
        input logic [PW-1:0] b,
        input logic [PW-1:0] c
    );
        logic [PW-1:0] s;
        logic [PW-1:0] cy;
        s  = a ^ b ^ c;
        // Carry out of bit 31 is dropped: arithmetic is modulo 2^32.
        cy = ((a & b) | (a & c) | (b & c)) << 1;
        return {cy, s};
    endfunction

    logic [OPW:0]  w_ye;
    logic [PW-1:0] w_xs;
    logic [PW-1:0] w_mag;
    logic [PW-1:0] w_corr;
    logic [2:0]    w_t;
    logic [PW-1:0] w_pp [0:8];

    logic [PW-1:0] w_s0, w_c0, w_s1, w_c1, w_s2, w_c2;
    logic [PW-1:0] w_s3, w_c3, w_s4, w_c4;
    logic [PW-1:0] w_s5, w_c5, w_s6, w_c6;

    // Negative digits use ~mag here; the +1 of each negation is
    // collected in a separate correction row (bits never overlap).
    always_comb begin
        w_ye   = {y, 1'b0};
        w_xs   = {{(PW-OPW){x[OPW-1]}}, x};
        w_corr = '0;
        w_t    = '0;
        w_mag  = '0;
        for (int i = 0; i < 8; i++) begin
            w_t = w_ye[2*i +: 3];
            unique case (w_t)
                3'b001, 3'b010,
                3'b101, 3'b110: w_mag = w_xs;
                3'b011, 3'b100: w_mag = w_xs << 1;
                default:        w_mag = '0;
            endcase
            w_pp[i]       = (w_t[2] ? ~w_mag : w_mag) << (2*i);
            w_corr[2*i]   = w_t[2];
        end
        w_pp[8] = w_corr;
    end

    always_comb begin
        {w_c0, w_s0} = csa(w_pp[0], w_pp[1], w_pp[2]);
        {w_c1, w_s1} = csa(w_pp[3], w_pp[4], w_pp[5]);
        {w_c2, w_s2} = csa(w_pp[6], w_pp[7], w_pp[8]);
        {w_c3, w_s3} = csa(w_s0, w_c0, w_s1);
        {w_c4, w_s4} = csa(w_c1, w_s2, w_c2);
        {w_c5, w_s5} = csa(w_s3, w_c3, w_s4);
        {w_c6, w_s6} = csa(w_s5, w_c5, w_c4);
    end

    assign p = w_s6 + w_c6;

endmodule

// File: rtl/mult_rr_scheduler_rr_arbiter.sv
// Round-robin arbiter: picks the first active request at or after ptr.
// Ports: req (requests), en (grant enable), ptr (priority start),
//        gnt (one-hot grant), gnt_idx (granted index), any (a grant
//        is issued), nxt_ptr (index just after the granted one).
module rr_arbiter
    import mult_rr_scheduler_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = idw_f(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic            en,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_idx,
    output logic            any,
    output logic [IDW-1:0]  nxt_ptr
);

    logic           w_found;
    logic [IDW-1:0] w_idx;
    int             w_best;
    int             w_dist;
    int             w_nxt;

    // Distance of each requester from ptr in the circular order;
    // the smallest distance among active requests wins.
    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        w_best  = NREQ;
        w_dist  = 0;
        for (int i = 0; i < NREQ; i++) begin
            w_dist = i - int'(ptr);
            if (w_dist < 0) w_dist = w_dist + NREQ;
            if (req[i] && (w_dist < w_best)) begin
                w_best  = w_dist;
                w_found = 1'b1;
                w_idx   = IDW'(i);
            end
        end
    end

    always_comb begin
        w_nxt = int'(w_idx) + 1;
        if (w_nxt >= NREQ) w_nxt = 0;
    end

    assign any     = en & w_found;
    assign gnt_idx = w_idx;
    assign nxt_ptr = IDW'(w_nxt);
    assign gnt     = any ? NREQ'(onehot16(4'(w_idx))) : '0;

endmodule

// File: rtl/mult_rr_scheduler.sv
// Shares one boothwallace multiplier among NREQ requesters.
// Round-robin grant into operand stage S1, product into result stage S2.
// Ports: clk, rst (async, active high); req_valid/req_ready/req_x/req_y
//        per requester; rsp_valid/rsp_ready/rsp_id/rsp_p tagged product.
module mult_rr_scheduler
    import mult_rr_scheduler_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = idw_f(NREQ)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*OPW-1:0] req_x,
    input  logic [NREQ*OPW-1:0] req_y,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [IDW-1:0]      rsp_id,
    output logic [PW-1:0]       rsp_p
);

    logic            r_s1_valid;
    logic [OPW-1:0]  r_s1_x;
    logic [OPW-1:0]  r_s1_y;
    logic [IDW-1:0]  r_s1_id;
    logic            r_s2_valid;
    logic [PW-1:0]   r_s2_p;
    logic [IDW-1:0]  r_s2_id;
    logic [IDW-1:0]  r_ptr;

    logic            w_s1_adv;
    logic            w_s2_adv;
    logic            w_en;
    logic [NREQ-1:0] w_gnt;
    logic [IDW-1:0]  w_gnt_idx;
    logic [IDW-1:0]  w_nxt_ptr;
    logic            w_any;
    logic [OPW-1:0]  w_x;
    logic [OPW-1:0]  w_y;
    logic [PW-1:0]   w_prod;

    // Both stages move together when the consumer drains S2.
    assign w_s2_adv = ~r_s2_valid | rsp_ready;
    assign w_s1_adv = ~r_s1_valid | w_s2_adv;
    // No grants are offered while reset is held.
    assign w_en     = w_s1_adv & ~rst;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req     (req_valid),
        .en      (w_en),
        .ptr     (r_ptr),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx),
        .any     (w_any),
        .nxt_ptr (w_nxt_ptr)
    );

    assign req_ready = w_gnt;

    // One-hot AND-OR operand select.
    always_comb begin
        w_x = '0;
        w_y = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt[i]) begin
                w_x = w_x | req_x[i*OPW +: OPW];
                w_y = w_y | req_y[i*OPW +: OPW];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_x     <= '0;
            r_s1_y     <= '0;
            r_s1_id    <= '0;
            r_ptr      <= '0;
        end else if (w_s1_adv) begin
            r_s1_valid <= w_any;
            if (w_any) begin
                r_s1_x  <= w_x;
                r_s1_y  <= w_y;
                r_s1_id <= w_gnt_idx;
                r_ptr   <= w_nxt_ptr;
            end
        end
    end

    boothwallace u_mul (
        .x (r_s1_x),
        .y (r_s1_y),
        .p (w_prod)
    );

    // Result/tag reload only for a real product; otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_p     <= '0;
            r_s2_id    <= '0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_p  <= w_prod;
                r_s2_id <= r_s1_id;
            end
        end
    end

    assign rsp_valid = r_s2_valid;
    assign rsp_p     = r_s2_p;
    assign rsp_id    = r_s2_id;

endmodule
